// File: rtl/pulse_cmd_proc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pulse_cmd_proc                                             |
// | Description : UART command processor for the pulse generator. Frames     |
// |               CR/NL-terminated commands, decodes configuration writes    |
// |               and PRINT readback, and answers every frame with either    |
// |               the opcode or an error code.                               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pulse_cmd_proc #(
    parameter int  CH_LOG2    = 3,
    parameter int  COUNT_BITS = 32,
    parameter int  ED_MAX     = 64,
    parameter int  BYTES      = 16,
    localparam int CH_MAX     = 1 << CH_LOG2,
    localparam int ED_BITS    = 2 * COUNT_BITS + CH_LOG2 + 1
) (
    input  logic                      sys_clk,
    input  logic                      rst_n,
    input  logic                      rx_valid,
    input  logic [7:0]                rx_byte,
    output logic                      tx_start,
    output logic [7:0]                tx_byte,
    input  logic                      tx_busy,
    output logic [CH_MAX-1:0]         state0,
    output logic [COUNT_BITS-1:0]     period,
    output logic [COUNT_BITS-1:0]     outer_period,
    output logic [ED_BITS*ED_MAX-1:0] eds,
    output logic                      cfg_reset,
    output logic                      busy
);

    localparam int c_N_CNT    = (COUNT_BITS + 7) / 8;
    localparam int c_N_ED     = (ED_BITS + 7) / 8;
    localparam int c_IDX_W    = $clog2(BYTES + 1);
    localparam int c_BUF_AW   = $clog2(BYTES);
    localparam int c_ED_AW    = (ED_MAX > 1) ? $clog2(ED_MAX) : 1;
    localparam int c_RESP_MAX = 1 + c_N_ED;
    localparam int c_RN_W     = $clog2(c_RESP_MAX + 1);
    localparam int c_PV_W     = 8 * c_N_ED;

    localparam logic [c_IDX_W-1:0] c_BYTES    = c_IDX_W'(BYTES);
    localparam logic [c_IDX_W-1:0] c_LEN_ST0  = c_IDX_W'(2);
    localparam logic [c_IDX_W-1:0] c_LEN_CNT  = c_IDX_W'(1 + c_N_CNT);
    localparam logic [c_IDX_W-1:0] c_LEN_ED   = c_IDX_W'(2 + c_N_ED);
    localparam logic [c_IDX_W-1:0] c_LEN_PRT  = c_IDX_W'(2);
    localparam logic [c_IDX_W-1:0] c_LEN_PRT3 = c_IDX_W'(3);
    localparam logic [8:0]         c_ED_LIM   = 9'(ED_MAX);

    localparam logic [7:0] c_E0 = 8'hE0;
    localparam logic [7:0] c_E1 = 8'hE1;
    localparam logic [7:0] c_E2 = 8'hE2;
    localparam logic [7:0] c_E3 = 8'hE3;
    localparam logic [7:0] c_CR = 8'h0D;
    localparam logic [7:0] c_NL = 8'h0A;

    localparam logic [1:0] c_S_RX      = 2'd0;
    localparam logic [1:0] c_S_DECODE  = 2'd1;
    localparam logic [1:0] c_S_RESP    = 2'd2;
    localparam logic [1:0] c_S_TX_WAIT = 2'd3;

    logic [1:0]                r_state;
    logic [1:0]                w_state_next;
    logic [7:0]                r_buf [BYTES];
    logic [c_IDX_W-1:0]        r_idx;
    logic [c_IDX_W-1:0]        r_len;
    logic                      r_prev_cr;
    logic                      r_ovf;
    logic [CH_MAX-1:0]         r_state0;
    logic [COUNT_BITS-1:0]     r_period;
    logic [COUNT_BITS-1:0]     r_outer;
    logic [ED_BITS-1:0]        r_eds [ED_MAX];
    logic                      r_cfg_reset;
    logic                      r_tx_start;
    logic [7:0]                r_tx_byte;
    logic [8*c_RESP_MAX-1:0]   r_resp;
    logic [c_RN_W-1:0]         r_resp_n;
    logic [c_RN_W-1:0]         r_resp_i;
    logic                      r_wait1;

    logic                      w_term;
    logic [7:0]                w_op;
    logic [COUNT_BITS-1:0]     w_cnt_val;
    logic [ED_BITS-1:0]        w_ed_val;
    logic [c_ED_AW-1:0]        w_wr_idx;
    logic [c_ED_AW-1:0]        w_rd_idx;
    logic                      w_ok;
    logic [7:0]                w_code;
    logic [c_PV_W-1:0]         w_pval;
    logic [c_RN_W-1:0]         w_resp_n;
    logic [8*c_RESP_MAX-1:0]   w_resp;
    logic                      w_emit;
    logic [7:0]                w_emit_byte;

    assign w_term = rx_valid && (rx_byte == c_NL) && r_prev_cr;

    // Decode the buffered frame: validate, pick the response code and PRINT value
    always_comb begin
        w_op      = r_buf[0];
        w_cnt_val = '0;
        w_ed_val  = '0;
        for (int b = 0; b < COUNT_BITS; b++) w_cnt_val[b] = r_buf[1 + b / 8][b % 8];
        for (int b = 0; b < ED_BITS; b++)    w_ed_val[b]  = r_buf[2 + b / 8][b % 8];
        w_wr_idx  = r_buf[1][c_ED_AW-1:0];
        w_rd_idx  = r_buf[2][c_ED_AW-1:0];
        w_ok      = 1'b0;
        w_code    = c_E1;
        w_pval    = '0;
        w_resp_n  = c_RN_W'(1);
        if (r_ovf) begin
            w_code = c_E0;
        end else if (r_len != '0) begin
            case (w_op)
                8'd0: if (r_len >= c_LEN_ST0) w_ok = 1'b1;
                8'd1, 8'd3: if (r_len >= c_LEN_CNT) w_ok = 1'b1;
                8'd2: begin
                    if (r_len < c_LEN_ED)                      w_code = c_E1;
                    else if ({1'b0, r_buf[1]} >= c_ED_LIM)     w_code = c_E3;
                    else                                       w_ok   = 1'b1;
                end
                8'd4: begin
                    if (r_len < c_LEN_PRT)                                 w_code = c_E1;
                    else if (r_buf[1] == 8'd3 && r_len < c_LEN_PRT3)       w_code = c_E1;
                    else if (r_buf[1] > 8'd3)                              w_code = c_E2;
                    else if (r_buf[1] == 8'd3 && {1'b0, r_buf[2]} >= c_ED_LIM) w_code = c_E3;
                    else begin
                        w_ok = 1'b1;
                        case (r_buf[1][1:0])
                            2'd0: begin w_pval = c_PV_W'(r_state0); w_resp_n = c_RN_W'(2); end
                            2'd1: begin w_pval = c_PV_W'(r_period); w_resp_n = c_RN_W'(1 + c_N_CNT); end
                            2'd2: begin w_pval = c_PV_W'(r_outer);  w_resp_n = c_RN_W'(1 + c_N_CNT); end
                            default: begin
                                w_pval   = c_PV_W'(r_eds[w_rd_idx]);
                                w_resp_n = c_RN_W'(1 + c_N_ED);
                            end
                        endcase
                    end
                end
                8'd5:    w_ok   = 1'b1;
                default: w_code = c_E2;
            endcase
        end
        if (w_ok) w_code = w_op;
        w_resp = {w_pval, w_code};
    end

    // FSM state register
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_S_RX;
        else        r_state <= w_state_next;
    end

    // Next-state and transmit-strobe decision; a byte only goes out when the uart is idle
    always_comb begin
        w_state_next = r_state;
        w_emit       = 1'b0;
        w_emit_byte  = r_resp[8*r_resp_i +: 8];
        case (r_state)
            c_S_RX: if (w_term) w_state_next = c_S_DECODE;
            c_S_DECODE: begin
                if (!tx_busy) begin
                    w_emit       = 1'b1;
                    w_emit_byte  = w_resp[7:0];
                    w_state_next = c_S_TX_WAIT;
                end else begin
                    w_state_next = c_S_RESP;
                end
            end
            c_S_RESP: begin
                if (!tx_busy) begin
                    w_emit       = 1'b1;
                    w_state_next = c_S_TX_WAIT;
                end
            end
            c_S_TX_WAIT: begin
                // First cycle after a strobe the uart has not raised tx_busy yet
                if (!r_wait1 && !tx_busy)
                    w_state_next = (r_resp_i == r_resp_n) ? c_S_RX : c_S_RESP;
            end
            default: w_state_next = c_S_RX;
        endcase
    end

    // Framing, configuration registers and response sequencing
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BYTES; i++) r_buf[i] <= '0;
            for (int k = 0; k < ED_MAX; k++) r_eds[k] <= '0;
            r_idx       <= '0;
            r_len       <= '0;
            r_prev_cr   <= 1'b0;
            r_ovf       <= 1'b0;
            r_state0    <= '0;
            r_period    <= COUNT_BITS'(1);
            r_outer     <= COUNT_BITS'(1);
            r_cfg_reset <= 1'b0;
            r_tx_start  <= 1'b0;
            r_tx_byte   <= '0;
            r_resp      <= '0;
            r_resp_n    <= '0;
            r_resp_i    <= '0;
            r_wait1     <= 1'b0;
        end else begin
            r_cfg_reset <= 1'b0;
            r_tx_start  <= w_emit;
            if (w_emit) r_tx_byte <= w_emit_byte;
            case (r_state)
                c_S_RX: begin
                    if (w_term) begin
                        r_len     <= r_idx - c_IDX_W'(1);
                        r_idx     <= '0;
                        r_prev_cr <= 1'b0;
                    end else if (rx_valid) begin
                        r_prev_cr <= (rx_byte == c_CR);
                        if (r_idx == c_BYTES) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_buf[r_idx[c_BUF_AW-1:0]] <= rx_byte;
                            r_idx <= r_idx + c_IDX_W'(1);
                        end
                    end
                end
                c_S_DECODE: begin
                    // A byte landing during DECODE already belongs to the next frame
                    r_ovf    <= rx_valid;
                    r_resp   <= w_resp;
                    r_resp_n <= w_resp_n;
                    r_resp_i <= w_emit ? c_RN_W'(1) : '0;
                    r_wait1  <= 1'b1;
                    if (w_ok) begin
                        case (w_op)
                            8'd0: r_state0 <= CH_MAX'(r_buf[1]);
                            8'd1: r_period <= w_cnt_val;
                            8'd2: r_eds[w_wr_idx] <= w_ed_val;
                            8'd3: r_outer <= w_cnt_val;
                            8'd5: for (int k = 0; k < ED_MAX; k++) r_eds[k] <= '0;
                            default: ;
                        endcase
                        if (w_op != 8'd4) r_cfg_reset <= 1'b1;
                    end
                end
                c_S_RESP: begin
                    if (rx_valid) r_ovf <= 1'b1;
                    if (w_emit) begin
                        r_resp_i <= r_resp_i + c_RN_W'(1);
                        r_wait1  <= 1'b1;
                    end
                end
                default: begin
                    if (rx_valid) r_ovf <= 1'b1;
                    r_wait1 <= 1'b0;
                end
            endcase
        end
    end

    generate
        for (genvar k = 0; k < ED_MAX; k++) begin : g_eds
            assign eds[ED_BITS*k +: ED_BITS] = r_eds[k];
        end
    endgenerate

    assign state0       = r_state0;
    assign period       = r_period;
    assign outer_period = r_outer;
    assign cfg_reset    = r_cfg_reset;
    assign tx_start     = r_tx_start;
    assign tx_byte      = r_tx_byte;
    assign busy         = (r_state != c_S_RX);

endmodule
`default_nettype wire

// File: tb/tb_pulse_cmd_proc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pulse_cmd_proc                                          |
// | Description : Self-checking bench for pulse_cmd_proc with a uart model,  |
// |               a reference register model and a tx byte scoreboard.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_pulse_cmd_proc;

    localparam int CH_MAX     = 8;
    localparam int COUNT_BITS = 32;
    localparam int ED_MAX     = 64;
    localparam int ED_BITS    = 68;

    logic                      sys_clk   = 1'b0;
    logic                      rst_n     = 1'b0;
    logic                      rx_valid  = 1'b0;
    logic [7:0]                rx_byte   = 8'h00;
    logic                      hold_busy = 1'b0;
    int                        ucnt      = 0;
    logic                      tx_busy;
    logic                      tx_start;
    logic [7:0]                tx_byte;
    logic [CH_MAX-1:0]         state0;
    logic [COUNT_BITS-1:0]     period;
    logic [COUNT_BITS-1:0]     outer_period;
    logic [ED_BITS*ED_MAX-1:0] eds;
    logic                      cfg_reset;
    logic                      busy;

    int checks    = 0;
    int errors    = 0;
    int tx_count  = 0;
    int cfg_count = 0;

    logic [7:0]            exp_q [$];
    logic [7:0]            frm [$];
    logic [7:0]            mon_exp;
    logic [CH_MAX-1:0]     m_state0;
    logic [COUNT_BITS-1:0] m_period;
    logic [COUNT_BITS-1:0] m_outer;
    logic [ED_BITS-1:0]    m_eds [ED_MAX];

    pulse_cmd_proc dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .rx_valid     (rx_valid),
        .rx_byte      (rx_byte),
        .tx_start     (tx_start),
        .tx_byte      (tx_byte),
        .tx_busy      (tx_busy),
        .state0       (state0),
        .period       (period),
        .outer_period (outer_period),
        .eds          (eds),
        .cfg_reset    (cfg_reset),
        .busy         (busy)
    );

    always #5 sys_clk = ~sys_clk;

    // uart model: busy rises one cycle after the strobe and lasts three cycles
    assign tx_busy = (ucnt != 0) || hold_busy;
    always @(posedge sys_clk) begin
        if (tx_start === 1'b1) ucnt <= 3;
        else if (ucnt != 0)    ucnt <= ucnt - 1;
    end

    // tx scoreboard and cfg_reset pulse counter
    always @(negedge sys_clk) begin
        if (cfg_reset === 1'b1) cfg_count++;
        if (tx_start === 1'b1) begin
            tx_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected got %02h expected none", tx_byte);
            end else begin
                mon_exp = exp_q.pop_front();
                if (tx_byte !== mon_exp) begin
                    errors++;
                    $display("FAIL tx_byte got %02h expected %02h", tx_byte, mon_exp);
                end
            end
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [ED_BITS*ED_MAX-1:0] flat_eds();
        logic [ED_BITS*ED_MAX-1:0] v;
        v = '0;
        for (int k = 0; k < ED_MAX; k++) v[ED_BITS*k +: ED_BITS] = m_eds[k];
        return v;
    endfunction

    task automatic model_reset();
        m_state0 = '0;
        m_period = 32'd1;
        m_outer  = 32'd1;
        for (int k = 0; k < ED_MAX; k++) m_eds[k] = '0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge sys_clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame();
        foreach (frm[i]) send_byte(frm[i]);
        send_byte(8'h0D);
        send_byte(8'h0A);
        frm.delete();
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < max_cycles) begin
            @(posedge sys_clk); #1;
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout got busy=%b expected 0", busy);
        end
    endtask

    task automatic push_ed_bytes(input int k);
        logic [71:0] v;
        v = {4'b0, m_eds[k]};
        for (int i = 0; i < 9; i++) exp_q.push_back(v[8*i +: 8]);
    endtask

    task automatic test_reset();
        checks++; if (state0 !== m_state0) begin errors++; $display("FAIL rst_state0 got %h expected %h", state0, m_state0); end
        checks++; if (period !== 32'd1) begin errors++; $display("FAIL rst_period got %h expected 1", period); end
        checks++; if (outer_period !== 32'd1) begin errors++; $display("FAIL rst_outer got %h expected 1", outer_period); end
        checks++; if (eds !== flat_eds()) begin errors++; $display("FAIL rst_eds got nonzero expected zero"); end
        checks++; if (tx_start !== 1'b0 || tx_byte !== 8'h00) begin errors++; $display("FAIL rst_tx got %b/%h expected 0/00", tx_start, tx_byte); end
        checks++; if (cfg_reset !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_ctl got %b/%b expected 0/0", cfg_reset, busy); end
    endtask

    task automatic test_period();
        int c0;
        c0  = cfg_count;
        frm = '{8'h01, 8'h10, 8'h27, 8'h00, 8'h00};
        exp_q.push_back(8'h01);
        send_frame();
        checks++; if (period !== m_period || busy !== 1'b1) begin errors++; $display("FAIL per_decode got %h/%b expected %h/1", period, busy, m_period); end
        @(posedge sys_clk); #1;
        m_period = 32'd10000;
        checks++; if (period !== m_period) begin errors++; $display("FAIL per_value got %h expected %h", period, m_period); end
        checks++; if (cfg_reset !== 1'b1 || tx_start !== 1'b1) begin errors++; $display("FAIL per_t2 got cfg=%b tx=%b expected 1/1", cfg_reset, tx_start); end
        @(posedge sys_clk); #1;
        checks++; if (cfg_reset !== 1'b0 || tx_start !== 1'b0) begin errors++; $display("FAIL per_t3 got cfg=%b tx=%b expected 0/0", cfg_reset, tx_start); end
        wait_idle(200);
        checks++; if (exp_q.size() != 0 || cfg_count != c0 + 1) begin errors++; $display("FAIL per_end got q=%0d cfg=%0d expected 0/%0d", exp_q.size(), cfg_count, c0 + 1); end
    endtask

    task automatic test_edge_print();
        logic [7:0] ea [9];
        logic [7:0] eb [9];
        int c0;
        ea = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h09};
        eb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0F};
        c0 = cfg_count;
        frm = '{8'h02, 8'h05};
        for (int i = 0; i < 9; i++) frm.push_back(ea[i]);
        exp_q.push_back(8'h02);
        send_frame(); wait_idle(200);
        m_eds[5] = 68'h9_8877665544332211;
        checks++; if (eds !== flat_eds()) begin errors++; $display("FAIL ed5 got %h expected %h", eds[ED_BITS*5 +: ED_BITS], m_eds[5]); end
        frm = '{8'h02, 8'h3F};
        for (int i = 0; i < 9; i++) frm.push_back(eb[i]);
        exp_q.push_back(8'h02);
        send_frame(); wait_idle(200);
        m_eds[63] = 68'hF_0807060504030201;
        checks++; if (eds !== flat_eds()) begin errors++; $display("FAIL ed63 got %h expected %h", eds[ED_BITS*63 +: ED_BITS], m_eds[63]); end
        frm = '{8'h04, 8'h03, 8'h05};
        exp_q.push_back(8'h04); push_ed_bytes(5);
        send_frame(); wait_idle(300);
        frm = '{8'h04, 8'h03, 8'h3F};
        exp_q.push_back(8'h04); push_ed_bytes(63);
        send_frame(); wait_idle(300);
        frm = '{8'h04, 8'h01};
        exp_q.push_back(8'h04);
        for (int i = 0; i < 4; i++) exp_q.push_back(m_period[8*i +: 8]);
        send_frame(); wait_idle(200);
        frm = '{8'h04, 8'h00};
        exp_q.push_back(8'h04); exp_q.push_back(m_state0);
        send_frame(); wait_idle(200);
        frm = '{8'h04, 8'h02, 8'h55};
        exp_q.push_back(8'h04);
        for (int i = 0; i < 4; i++) exp_q.push_back(m_outer[8*i +: 8]);
        send_frame(); wait_idle(200);
        checks++; if (exp_q.size() != 0 || cfg_count != c0 + 2) begin errors++; $display("FAIL edprint_end got q=%0d cfg=%0d expected 0/%0d", exp_q.size(), cfg_count, c0 + 2); end
    endtask

    task automatic test_ed_range();
        int c0;
        c0  = cfg_count;
        frm = '{8'h02, 8'h40};
        for (int i = 0; i < 9; i++) frm.push_back(8'hA0 + 8'(i));
        exp_q.push_back(8'hE3);
        send_frame(); wait_idle(200);
        checks++; if (eds !== flat_eds()) begin errors++; $display("FAIL edrange_eds got changed expected unchanged"); end
        checks++; if (cfg_count != c0 || exp_q.size() != 0) begin errors++; $display("FAIL edrange_cfg got cfg=%0d q=%0d expected %0d/0", cfg_count, exp_q.size(), c0); end
    endtask

    task automatic test_errors();
        int c0;
        c0 = cfg_count;
        frm = '{8'h01};               exp_q.push_back(8'hE1); send_frame(); wait_idle(200);
        frm = '{8'h07};               exp_q.push_back(8'hE2); send_frame(); wait_idle(200);
        frm.delete();                 exp_q.push_back(8'hE1); send_frame(); wait_idle(200);
        frm = '{8'h04};               exp_q.push_back(8'hE1); send_frame(); wait_idle(200);
        frm = '{8'h04, 8'h05};        exp_q.push_back(8'hE2); send_frame(); wait_idle(200);
        frm = '{8'h04, 8'h03};        exp_q.push_back(8'hE1); send_frame(); wait_idle(200);
        frm = '{8'h04, 8'h03, 8'h40}; exp_q.push_back(8'hE3); send_frame(); wait_idle(200);
        frm = '{8'h02, 8'h05, 8'h11}; exp_q.push_back(8'hE1); send_frame(); wait_idle(200);
        checks++; if (cfg_count != c0 || exp_q.size() != 0) begin errors++; $display("FAIL err_cfg got cfg=%0d q=%0d expected %0d/0", cfg_count, exp_q.size(), c0); end
        checks++; if (period !== m_period || state0 !== m_state0 || eds !== flat_eds()) begin errors++; $display("FAIL err_regs got per=%h st0=%h expected %h/%h", period, state0, m_period, m_state0); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 20; i++) frm.push_back(8'h30 + 8'(i));
        exp_q.push_back(8'hE0);
        send_frame(); wait_idle(200);
        checks++; if (state0 !== m_state0) begin errors++; $display("FAIL ovf_state0 got %h expected %h", state0, m_state0); end
        frm = '{8'h00, 8'hA5};
        exp_q.push_back(8'h00);
        send_frame(); wait_idle(200);
        m_state0 = 8'hA5;
        checks++; if (state0 !== m_state0 || exp_q.size() != 0) begin errors++; $display("FAIL ovf_recover got %h q=%0d expected %h/0", state0, exp_q.size(), m_state0); end
    endtask

    task automatic test_busy_hold();
        int t0;
        int c0;
        t0 = tx_count;
        c0 = cfg_count;
        hold_busy = 1'b1;
        frm = '{8'h05};
        exp_q.push_back(8'h05);
        send_frame();
        send_byte(8'h77);
        repeat (15) @(posedge sys_clk);
        #1;
        for (int k = 0; k < ED_MAX; k++) m_eds[k] = '0;
        checks++; if (tx_count != t0 || busy !== 1'b1) begin errors++; $display("FAIL hold_tx got %0d/%b expected %0d/1", tx_count, busy, t0); end
        checks++; if (eds !== flat_eds() || cfg_count != c0 + 1) begin errors++; $display("FAIL hold_clear got cfg=%0d expected %0d", cfg_count, c0 + 1); end
        hold_busy = 1'b0;
        wait_idle(200);
        checks++; if (tx_count != t0 + 1) begin errors++; $display("FAIL hold_release got %0d expected %0d", tx_count, t0 + 1); end
        frm = '{8'h00, 8'h5A};
        exp_q.push_back(8'hE0);
        send_frame(); wait_idle(200);
        checks++; if (state0 !== m_state0) begin errors++; $display("FAIL busy_drop got %h expected %h", state0, m_state0); end
        frm = '{8'h00, 8'h5A};
        exp_q.push_back(8'h00);
        send_frame(); wait_idle(200);
        m_state0 = 8'h5A;
        checks++; if (state0 !== m_state0 || exp_q.size() != 0) begin errors++; $display("FAIL busy_after got %h q=%0d expected %h/0", state0, exp_q.size(), m_state0); end
    endtask

    task automatic test_reset_mid();
        int n;
        int t0;
        frm = '{8'h04, 8'h01};
        exp_q.push_back(8'h04);
        for (int i = 0; i < 4; i++) exp_q.push_back(m_period[8*i +: 8]);
        send_frame();
        n = 0;
        while (tx_start !== 1'b1 && n < 50) begin
            @(posedge sys_clk); #1;
            n++;
        end
        checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL mid_first got %b expected 1", tx_start); end
        @(negedge sys_clk); #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        model_reset();
        checks++; if (period !== m_period || state0 !== m_state0 || eds !== flat_eds()) begin errors++; $display("FAIL mid_regs got per=%h st0=%h expected %h/%h", period, state0, m_period, m_state0); end
        checks++; if (tx_start !== 1'b0 || busy !== 1'b0 || cfg_reset !== 1'b0) begin errors++; $display("FAIL mid_ctl got %b/%b/%b expected 0/0/0", tx_start, busy, cfg_reset); end
        repeat (3) @(posedge sys_clk);
        #1;
        rst_n = 1'b1;
        t0 = tx_count;
        repeat (20) @(posedge sys_clk);
        #1;
        checks++; if (tx_count != t0 || busy !== 1'b0) begin errors++; $display("FAIL mid_quiet got %0d/%b expected %0d/0", tx_count, busy, t0); end
        frm = '{8'h00, 8'h3C};
        exp_q.push_back(8'h00);
        send_frame(); wait_idle(200);
        m_state0 = 8'h3C;
        checks++; if (state0 !== m_state0 || exp_q.size() != 0) begin errors++; $display("FAIL mid_next got %h q=%0d expected %h/0", state0, exp_q.size(), m_state0); end
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge sys_clk);
        #1;
        rst_n = 1'b1;
        @(posedge sys_clk); #1;
        test_reset();
        test_period();
        test_edge_print();
        test_ed_range();
        test_errors();
        test_overflow();
        test_busy_hold();
        test_reset_mid();
        repeat (5) @(posedge sys_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
